channel_select_controller: RTL
==============================

# channel_select_controller

Automatic gain-channel selector that drives the `select` input of the two-channel combinator stage. It watches both ADC channel words on every `enable_3M` tick and moves to the low-gain channel (c2) when the high-gain channel (c1) nears full scale. It returns to c1 only after c2 has stayed quiet for a programmable hold time. After every change, further decisions are locked out until the combinator's alpha ramp has finished.

## Interface
- `UPPER_THR`, default 960: switch-to-c2 threshold on |data_c1|; unsigned 11-bit; must be greater than LOWER_THR.
- `LOWER_THR`, default 96: switch-back threshold on |data_c2|; unsigned 11-bit.
- `HOLD_TICKS`, default 3000: consecutive quiet ticks required before returning to c1; at least 1.
- `LOCKOUT_TICKS`, default 16: ticks frozen after each change; equals the combinator ramp length; at least 1.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-low.
- `enable_3M`  in  1  single-cycle sample tick; all decisions are made only on these cycles.
- `data_c1`  in  11  high-gain channel sample, two's complement.
- `data_c2`  in  11  low-gain channel sample, two's complement.
- `select`  out  1  0 = c1, 1 = c2; registered; connects to the combinator `select`.
- `switching`  out  1  high during lockout.
- `force_en`, `force_sel`  in  1 each  present only with CHSEL_FORCE_EN (see Configuration).

## Operation
- Magnitude: |x| is an 11-bit unsigned value; -1024 maps to 1024. There is no saturation and no wrap.
- States: HIGH_GAIN, TO_LOW, LOW_GAIN, TO_HIGH. Every transition happens only on a cycle where `enable_3M` is high.
- HIGH_GAIN, select=0:
  - If |data_c1| >= UPPER_THR on a tick, go to TO_LOW and set select=1.
  - Equality counts as a crossing.
- TO_LOW / TO_HIGH (lockout):
  - The lockout counter is loaded on entry and decremented on each tick.
  - After LOCKOUT_TICKS ticks, enter LOW_GAIN or HIGH_GAIN respectively.
  - Threshold crossings during lockout are ignored and are not remembered.
- LOW_GAIN, select=1:
  - The hold counter starts at 0 on entry.
  - Each tick with |data_c2| < LOWER_THR increments the counter.
  - Any tick with |data_c2| >= LOWER_THR clears the counter to 0.
  - On the tick where the counter reaches HOLD_TICKS, go to TO_HIGH and set select=0.
- The hold counter saturates at HOLD_TICKS. Its width is $clog2(HOLD_TICKS+1).
- Cycles where `enable_3M` is low change nothing, and the data inputs are ignored on those cycles.

## Timing
- Reset values: select=0, switching=0, state HIGH_GAIN, both counters 0.
- Reset is sampled on any clk edge, independent of `enable_3M`. A reset asserted mid-lockout or mid-hold aborts immediately to the reset values.
- Decision latency: `select` changes at the clock edge of the deciding tick and is visible in the following cycle. It is therefore stable before the combinator's next tick.
- Lockout timing, with N = the deciding tick:
  - `switching` rises together with the `select` change.
  - `switching` stays high through tick N+LOCKOUT_TICKS and falls at that edge.
  - The first tick evaluated for a new decision is N+LOCKOUT_TICKS+1.
- Fastest round trip: UPPER crossing, then LOCKOUT_TICKS, then HOLD_TICKS quiet ticks, then select=0. With defaults this is 3016 ticks.

## Configuration
- Macro: `CHSEL_FORCE_EN`.
- Defined:
  - The `force_en` and `force_sel` ports exist.
  - In HIGH_GAIN or LOW_GAIN with force_en=1 on a tick, the thresholds are ignored and the hold counter is held at 0.
  - If force_sel differs from select, the block enters the matching TO_ state with normal lockout.
  - Force is not honoured during lockout; it is evaluated on the first tick after lockout.
- Undefined: the ports are absent and operation is fully automatic.

## Structure
- Package `channel_select_pkg` contains:
  - `chsel_state_t` enum (HIGH_GAIN, TO_LOW, LOW_GAIN, TO_HIGH);
  - default threshold, hold and lockout constants;
  - `abs11` function.
- Sub-module `tick_counter`: a loadable, tick-enabled, saturating down/up counter. It is instantiated twice, once for lockout and once for hold.

## Test plan
- Reset, then run with |c1|=500 and |c2|=40 for 100 ticks: select=0 and switching=0 throughout.
- c1=960 on tick 10: select=1 after tick 10; switching is high through tick 26; c1=-1024 during ticks 11–26 causes no change.
- In LOW_GAIN, c2=50 for 2999 ticks, then c2=96 for one tick, then c2=50: the hold counter clears and select returns to 0 only after 3000 further quiet ticks.
- Boundary values: c1=959 gives no switch, c2=96 counts as not quiet, c2=95 counts as quiet.
- Reset asserted at lockout tick 5 while `enable_3M`=0: at the next edge select=0, switching=0, state HIGH_GAIN.
- With CHSEL_FORCE_EN: force_en=1 and force_sel=1 while c1=0 gives select=1 with 16-tick lockout. Force toggled during lockout is ignored until tick 17.

Source files
------------

// File: rtl/channel_select_pkg.sv
// Shared types, default tuning constants and the 11-bit magnitude helper
// for the automatic gain-channel selector.
package channel_select_pkg;

   typedef enum logic [1:0] {
      HIGH_GAIN = 2'd0,
      TO_LOW    = 2'd1,
      LOW_GAIN  = 2'd2,
      TO_HIGH   = 2'd3
   } chsel_state_t;

   localparam logic [10:0] DEF_UPPER_THR     = 11'd960;
   localparam logic [10:0] DEF_LOWER_THR     = 11'd96;
   localparam int unsigned DEF_HOLD_TICKS    = 3000;
   localparam int unsigned DEF_LOCKOUT_TICKS = 16;

   // -1024 negates to 11'h400, read as unsigned 1024, so no saturation is needed.
   function automatic logic [10:0] abs11(input logic [10:0] x);
      return x[10] ? (~x + 11'd1) : x;
   endfunction

endpackage

// File: rtl/channel_select_controller_tick_counter.sv
// Loadable, tick-enabled counter that saturates at MAX_VAL counting up and
// at zero counting down. Load takes priority over the tick.
module tick_counter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MAX_VAL = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             tick_i,
   input  logic             up_i,
   output logic [WIDTH-1:0] count_o
);

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      // NOTE: count_d takes its default first, so no branch leaves it unassigned and no latch is inferred.
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (tick_i) begin
         if (up_i) begin
            if (count_q < MAX_W) count_d = count_q + 1'b1;
         end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   // NOTE: non-blocking assignment makes every flop sample pre-edge values, independent of block order.
   always_ff @(posedge clk) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/channel_select_controller.sv
// Gain-channel selector: moves to c2 when c1 nears full scale, returns after a quiet hold.
// Optional manual override ports are built when CHSEL_FORCE_EN is defined.
module channel_select_controller
   import channel_select_pkg::*;
#(
   parameter logic [10:0] UPPER_THR     = DEF_UPPER_THR,
   parameter logic [10:0] LOWER_THR     = DEF_LOWER_THR,
   parameter int unsigned HOLD_TICKS    = DEF_HOLD_TICKS,
   parameter int unsigned LOCKOUT_TICKS = DEF_LOCKOUT_TICKS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable_3M,
   input  logic [10:0] data_c1,
   input  logic [10:0] data_c2,
`ifdef CHSEL_FORCE_EN
   input  logic        force_en,
   input  logic        force_sel,
`endif
   output logic        select,
   output logic        switching
);

   localparam int LOCK_W = $clog2(LOCKOUT_TICKS + 1);
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

   chsel_state_t      state_q, state_d;
   logic              select_q, select_d;
   logic [LOCK_W-1:0] lock_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic              lock_load, hold_clear, hold_inc;
   logic              c1_hot, c2_quiet, force_act, force_to;

   assign c1_hot   = abs11(data_c1) >= UPPER_THR;
   assign c2_quiet = abs11(data_c2) <  LOWER_THR;

`ifdef CHSEL_FORCE_EN
   assign force_act = force_en;
   assign force_to  = force_sel;
`else
   assign force_act = 1'b0;
   assign force_to  = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      select_d   = select_q;
      lock_load  = 1'b0;
      hold_inc   = 1'b0;
      hold_clear = (state_q != LOW_GAIN);
      if (enable_3M) begin
         case (state_q)
            HIGH_GAIN: begin
               if (force_act ? force_to : c1_hot) begin
                  state_d   = TO_LOW;
                  select_d  = 1'b1;
                  lock_load = 1'b1;
               end
            end
            TO_LOW: if (lock_cnt == LOCK_W'(1)) state_d = LOW_GAIN;
            LOW_GAIN: begin
               if (force_act || !c2_quiet) begin
                  hold_clear = 1'b1;
               end else begin
                  hold_inc = 1'b1;
               end
               // The quiet tick that takes the counter to HOLD_TICKS is the deciding tick.
               if (force_act ? !force_to
                             : (c2_quiet && hold_cnt == HOLD_W'(HOLD_TICKS - 1))) begin
                  state_d   = TO_HIGH;
                  select_d  = 1'b0;
                  lock_load = 1'b1;
               end
            end
            TO_HIGH: if (lock_cnt == LOCK_W'(1)) state_d = HIGH_GAIN;
            default: state_d = HIGH_GAIN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= HIGH_GAIN;
         select_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         select_q <= select_d;
      end
   end

   tick_counter #(
      .WIDTH   (LOCK_W),
      .MAX_VAL (LOCKOUT_TICKS)
   ) u_lockout (
      .clk        (clk),
      .reset      (reset),
      .load_i     (lock_load),
      .load_val_i (LOCK_W'(LOCKOUT_TICKS)),
      .tick_i     (enable_3M),
      .up_i       (1'b0),
      .count_o    (lock_cnt)
   );

   tick_counter #(
      .WIDTH   (HOLD_W),
      .MAX_VAL (HOLD_TICKS)
   ) u_hold (
      .clk        (clk),
      .reset      (reset),
      .load_i     (hold_clear),
      .load_val_i ('0),
      .tick_i     (hold_inc),
      .up_i       (1'b1),
      .count_o    (hold_cnt)
   );

   assign select    = select_q;
   assign switching = (state_q == TO_LOW) || (state_q == TO_HIGH);

endmodule
